// File: rtl/div16s_8s_seq.sv
// Iterative signed divider: 16-bit dividend / 8-bit divisor, restoring on magnitudes, one quotient bit per cycle.
// Define DIV16S_FASTPATH_EN to bypass the iterations for divisors 0, +1 and -1.
module div16s_8s_seq #(
    parameter int NW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_zero,
    output logic          ovf
);

    generate
        if (NW != 16 || DW != 8) begin : g_bad_params
            $error("div16s_8s_seq supports only NW=16, DW=8");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [DW:0]   rem_reg, rem_next;
    logic [NW-1:0] quo_reg, quo_next;
    logic [DW:0]   dvs_mag_reg, dvs_mag_next;
    logic          sn_reg, sn_next;
    logic          sd_reg, sd_next;
    logic          zero_reg, zero_next;
    logic          ovfp_reg, ovfp_next;
    logic          valid_reg, valid_next;
    logic [NW-1:0] q_out_reg, q_out_next;
    logic [DW-1:0] r_out_reg, r_out_next;
    logic          dz_reg, dz_next;
    logic          ov_reg, ov_next;

    // Magnitudes are taken one bit wider so -32768 and -128 do not wrap.
    logic [NW:0]   dvd_ext, dvd_abs;
    logic [DW:0]   dvs_ext, dvs_abs;
    logic [DW:0]   shifted;
    logic [DW+1:0] trial;

    always_comb begin
        dvd_ext = {dividend[NW-1], dividend};
        dvd_abs = dvd_ext[NW] ? (~dvd_ext + 1'b1) : dvd_ext;
        dvs_ext = {divisor[DW-1], divisor};
        dvs_abs = dvs_ext[DW] ? (~dvs_ext + 1'b1) : dvs_ext;
        shifted = {rem_reg[DW-1:0], quo_reg[NW-1]};
        trial   = {1'b0, shifted} - {1'b0, dvs_mag_reg};
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        dvs_mag_next = dvs_mag_reg;
        sn_next      = sn_reg;
        sd_next      = sd_reg;
        zero_next    = zero_reg;
        ovfp_next    = ovfp_reg;
        valid_next   = valid_reg;
        q_out_next   = q_out_reg;
        r_out_next   = r_out_reg;
        dz_next      = dz_reg;
        ov_next      = ov_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    quo_next     = dvd_abs[NW-1:0];
                    dvs_mag_next = dvs_abs;
                    sn_next      = dividend[NW-1];
                    sd_next      = divisor[DW-1];
                    zero_next    = (divisor == '0);
                    ovfp_next    = (dividend == {1'b1, {(NW-1){1'b0}}}) && (divisor == '1);
                    rem_next     = '0;
                    cnt_next     = 4'd15;
                    state_next   = S_CALC;
`ifdef DIV16S_FASTPATH_EN
                    // With |divisor| <= 1 the loaded registers already hold the iterative result.
                    if (dvs_abs <= 9'd1) begin
                        state_next = S_FIX;
                    end
`endif
                end
            end
            S_CALC: begin
                if (!trial[DW+1]) begin
                    rem_next = trial[DW:0];
                    quo_next = {quo_reg[NW-2:0], 1'b1};
                end else begin
                    rem_next = shifted;
                    quo_next = {quo_reg[NW-2:0], 1'b0};
                end
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd0) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                if (zero_reg) begin
                    q_out_next = '1;
                    r_out_next = '0;
                end else begin
                    q_out_next = (sn_reg ^ sd_reg) ? (~quo_reg + 1'b1) : quo_reg;
                    r_out_next = sn_reg ? (~rem_reg[DW-1:0] + 1'b1) : rem_reg[DW-1:0];
                end
                dz_next    = zero_reg;
                ov_next    = ovfp_reg;
                valid_next = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    dz_next    = 1'b0;
                    ov_next    = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_mag_reg <= '0;
            sn_reg      <= 1'b0;
            sd_reg      <= 1'b0;
            zero_reg    <= 1'b0;
            ovfp_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            q_out_reg   <= '0;
            r_out_reg   <= '0;
            dz_reg      <= 1'b0;
            ov_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            dvs_mag_reg <= dvs_mag_next;
            sn_reg      <= sn_next;
            sd_reg      <= sd_next;
            zero_reg    <= zero_next;
            ovfp_reg    <= ovfp_next;
            valid_reg   <= valid_next;
            q_out_reg   <= q_out_next;
            r_out_reg   <= r_out_next;
            dz_reg      <= dz_next;
            ov_reg      <= ov_next;
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = valid_reg;
    assign quotient  = q_out_reg;
    assign remainder = r_out_reg;
    assign div_zero  = dz_reg;
    assign ovf       = ov_reg;

endmodule

// File: doc/div16s_8s_seq.md
Name: div16s_8s_seq

Overview:
- Iterative signed divider: 16-bit two's-complement dividend / 8-bit two's-complement divisor → 16-bit quotient plus 8-bit remainder.
- Inverse companion to the 8x8 signed multiplier family. Used to recover operands and check products in verification and datapath pipelines.
- One quotient bit per cycle, restoring algorithm on magnitudes, followed by a sign-correction step.
- valid/ready handshake on both the input and output sides.

Parameters:
- NW, 16, dividend and quotient width. Only the default is supported; any other value is a synthesis-time error.
- DW, 8, divisor and remainder width. Only the default is supported; any other value is a synthesis-time error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands are valid
- in_ready  out  1  divider can accept operands
- dividend  in  16  signed dividend
- divisor  in  8  signed divisor
- out_valid  out  1  result is valid
- out_ready  in  1  consumer accepts the result
- quotient  out  16  signed quotient, truncated toward zero
- remainder  out  8  signed remainder; sign follows the dividend
- div_zero  out  1  divisor was 0
- ovf  out  1  case -32768 / -1

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - in_ready=1, out_valid=0.
  - quotient=0, remainder=0, div_zero=0, ovf=0.
  - State=IDLE, iteration counter=0.
- Reset mid-operation aborts the division; no partial result is ever presented.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0:
    - latch |dividend| (17-bit safe) and |divisor|;
    - latch both operand signs;
    - clear the partial remainder;
    - counter=15;
    - go to CALC.
- CALC (edges E1..E16):
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude (9-bit compare). If non-negative, keep the difference and set quotient bit=1; otherwise quotient bit=0.
  - Counter decrements each edge; on counter==0 go to FIX.
- FIX (edge E17):
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend is negative.
  - Flags are computed here.
  - Go to DONE.
- DONE:
  - out_valid=1 from E17 onward, i.e. 17 cycles after the accept edge.
  - All outputs are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0 on that edge, in_ready=1, state=IDLE.
  - in_ready is 0 in CALC, FIX and DONE, so there is no overlap between an accept and a pending result.
- Divide by zero:
  - Iterations still run.
  - Result is forced to quotient=16'hFFFF, remainder=8'h00, div_zero=1, ovf=0.
- Overflow (-32768 / -1):
  - quotient=16'h8000 (wrapped), remainder=0, ovf=1.
- Divisor -128: magnitude 128 is handled by 9-bit magnitude arithmetic; no special case.
- Flags are valid only while out_valid=1. They clear on the handshake edge.
- Inputs sampled while in_ready=0 are ignored.

Optional Feature:
- Macro DIV16S_FASTPATH_EN.
- Defined:
  - In IDLE, a divisor of 0, +1 or -1 bypasses CALC and goes directly to FIX.
  - out_valid is asserted 1 cycle after the accept edge.
  - Results and flags are identical to the iterative path.
- Not defined:
  - Every division takes the full 17-cycle latency.
  - No bypass logic is synthesized.

Test Plan:
- 100 / 7 → quotient=14, remainder=2, flags=0, out_valid 17 cycles after accept (1 cycle for the ±1/0 fast path only).
- -100 / 7 → quotient=-14 (16'hFFF2), remainder=-2 (8'hFE).
- 100 / -7 → quotient=-14, remainder=2.
- -32768 / -1 → quotient=16'h8000, remainder=0, ovf=1. Also 5 / 0 → quotient=16'hFFFF, remainder=0, div_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable and in_ready=0 throughout. Then pulse out_ready → out_valid drops next edge and in_ready=1.
- Assert rst_n=0 at cycle 8 of CALC → all outputs reach reset values immediately. Then a new 1000 / -128 → quotient=-7, remainder=104.
